// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
// Shared types and constants for the SM83-style interrupt controller.
//   irq_t        : interrupt source numbering (bit index in IE/IF)
//   int_state_t  : controller state encoding (RUN / HALT / DISPATCH)
//   ADDR_IE/IF   : memory-mapped register addresses
//   irq_vec()    : RST vector for a given source index
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        IRQ_VBLANK = 3'd0,
        IRQ_STAT   = 3'd1,
        IRQ_TIMER  = 3'd2,
        IRQ_SERIAL = 3'd3,
        IRQ_JOYPAD = 3'd4
    } irq_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALT     = 2'd1,
        DISPATCH = 2'd2
    } int_state_t;

    localparam logic [15:0] ADDR_IE = 16'hFFFF;
    localparam logic [15:0] ADDR_IF = 16'hFF0F;

    // Vector of source idx: base + idx * stride, zero-extended to 16 bits.
    function automatic logic [15:0] irq_vec(input logic [7:0] base,
                                            input int         stride,
                                            input logic [2:0] idx);
        return {8'h00, base} + 16'(stride * int'(idx));
    endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// int_ctrl_prio_enc
// Combinational priority encoder for pending interrupts; the lowest set bit
// wins (source 0 is highest priority).
//   pending : pending request vector (IE & IF)
//   valid   : at least one bit of pending is set
//   index   : index of the lowest set bit (0 when valid=0)
// -----------------------------------------------------------------------------
module int_ctrl_prio_enc #(
    parameter int NUM_IRQ = 5
) (
    input  logic [NUM_IRQ-1:0] pending,
    output logic               valid,
    output logic [2:0]         index
);

    // Scan from the top down so the last hit (lowest index) sticks.
    always_comb begin
        valid = 1'b0;
        index = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                valid = 1'b1;
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// SM83-style interrupt controller. Holds IE/IF, IME with the one-instruction
// EI delay, and the HALT state; requests dispatch from the sequencer at
// instruction boundaries and supplies the RST vector on acknowledge.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   irq_pulse         one-cycle source requests, each sets its IF bit
//   addr/wr_en/wr_data/rd_en   CPU bus access to IE (FFFF) and IF (FF0F)
//   rd_data, rd_hit   registered read response, valid the cycle after rd_en
//   instr_done        instruction boundary this cycle
//   ei, di, reti, halt_req     instruction side effects from the decoder
//   irq_req           dispatch request to the sequencer
//   irq_ack           sequencer vector-select pulse during dispatch
//   irq_vector        registered dispatch target, held until the next ack
//   ime, halted       master enable, CPU stalled in HALT
//   halt_bug          one-cycle pulse when HALT is skipped (IME=0, pending)
//
// Handshake: irq_req is a level; in DISPATCH it stays high until a single
// irq_ack cycle, at which point vector, IF and IME are updated on that edge.
// irq_ack seen in any other state has no effect.
// -----------------------------------------------------------------------------
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         NUM_IRQ    = 5,
    parameter logic [7:0] VEC_BASE   = 8'h40,
    parameter int         VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_pulse,
    input  logic [15:0]        addr,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               rd_hit,
    input  logic               instr_done,
    input  logic               ei,
    input  logic               di,
    input  logic               reti,
    input  logic               halt_req,
    output logic               irq_req,
    input  logic               irq_ack,
    output logic [15:0]        irq_vector,
    output logic               ime,
    output logic               halted,
    output logic               halt_bug
);

    localparam logic [1:0] S_RUN      = RUN;
    localparam logic [1:0] S_HALT     = HALT;
    localparam logic [1:0] S_DISPATCH = DISPATCH;

    logic [1:0]         state_q, state_d;
    logic [7:0]         ie_q;
    logic [NUM_IRQ-1:0] if_q, if_d;
    logic               ime_q, ime_d;
    logic               ime_pend_q, ime_pend_d;
    logic               halt_bug_q, halt_bug_d;
    logic [15:0]        vec_q;
    logic [7:0]         rd_data_q;
    logic               rd_hit_q;

    logic [NUM_IRQ-1:0] pending;
    logic               pend_valid;
    logic [2:0]         pend_idx;
    logic               ie_sel, if_sel;
    logic               ack_take;
    logic               go_dispatch;

    assign pending  = ie_q[NUM_IRQ-1:0] & if_q;
    assign ie_sel   = (addr == ADDR_IE);
    assign if_sel   = (addr == ADDR_IF);
    assign ack_take = (state_q == S_DISPATCH) && irq_ack;

    int_ctrl_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .pending (pending),
        .valid   (pend_valid),
        .index   (pend_idx)
    );

    // Outside DISPATCH the request tracks IME & pending directly, so leaving
    // HALT with IME=1 presents the request as soon as RUN is re-entered.
    assign irq_req     = (state_q == S_DISPATCH) || (ime_q && pend_valid);
    assign go_dispatch = (state_q == S_RUN) && instr_done && irq_req;

    // IF: bus write, then ack clear, then source pulses (a pulse always wins).
    always_comb begin
        if_d = if_q;
        if (wr_en && if_sel)
            if_d = wr_data[NUM_IRQ-1:0];
        if (ack_take && pend_valid)
            if_d = if_d & ~(NUM_IRQ'(1) << pend_idx);
        if_d = if_d | irq_pulse;
    end

    // IME / EI delay. A pending EI is promoted at the next boundary; the
    // new EI is recorded after the promotion so back-to-back EIs still work.
    // DI is applied last so it overrides everything else.
    always_comb begin
        ime_d      = ime_q;
        ime_pend_d = ime_pend_q;
        if (instr_done && ime_pend_q) begin
            ime_d      = 1'b1;
            ime_pend_d = 1'b0;
        end
        if (instr_done && ei)
            ime_pend_d = 1'b1;
        if (reti)
            ime_d = 1'b1;
        if (ack_take)
            ime_d = 1'b0;
        if (di) begin
            ime_d      = 1'b0;
            ime_pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        halt_bug_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (go_dispatch)
                    state_d = S_DISPATCH;
                else if (halt_req) begin
                    // With IME=0 and something pending HALT does not stall.
                    if (pend_valid && !ime_q)
                        halt_bug_d = 1'b1;
                    else
                        state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (pend_valid)
                    state_d = S_RUN;
            end
            S_DISPATCH: begin
                if (irq_ack)
                    state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            ie_q       <= 8'h00;
            if_q       <= '0;
            ime_q      <= 1'b0;
            ime_pend_q <= 1'b0;
            halt_bug_q <= 1'b0;
            vec_q      <= 16'h0000;
            rd_data_q  <= 8'h00;
            rd_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_q       <= if_d;
            ime_q      <= ime_d;
            ime_pend_q <= ime_pend_d;
            halt_bug_q <= halt_bug_d;
            if (wr_en && ie_sel)
                ie_q <= wr_data;
            // A cancelled dispatch (nothing pending at ack) jumps to 0000.
            if (ack_take)
                vec_q <= pend_valid ? irq_vec(VEC_BASE, VEC_STRIDE, pend_idx) : 16'h0000;
            rd_hit_q <= rd_en && (ie_sel || if_sel);
            if (rd_en && if_sel)
                rd_data_q <= {{(8-NUM_IRQ){1'b1}}, if_q};
            else if (rd_en && ie_sel)
                rd_data_q <= ie_q;
            else
                rd_data_q <= 8'h00;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_hit     = rd_hit_q;
    assign irq_vector = vec_q;
    assign ime        = ime_q;
    assign halted     = (state_q == S_HALT);
    assign halt_bug   = halt_bug_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  irq_pulse = '0;
  logic [15:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_hit;
  logic        instr_done = 1'b0;
  logic        ei = 1'b0;
  logic        di = 1'b0;
  logic        reti = 1'b0;
  logic        halt_req = 1'b0;
  logic        irq_req;
  logic        irq_ack = 1'b0;
  logic [15:0] irq_vector;
  logic        ime;
  logic        halted;
  logic        halt_bug;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  exp_q[$];   // {rd_hit, rd_data}
  logic [15:0] vec_q[$];   // expected irq_vector after each ack
  logic        rd_armed  = 1'b0;
  logic        ack_armed = 1'b0;

  int_ctrl dut (
    .clk(clk), .rst(rst), .irq_pulse(irq_pulse), .addr(addr), .wr_en(wr_en),
    .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data), .rd_hit(rd_hit),
    .instr_done(instr_done), .ei(ei), .di(di), .reti(reti), .halt_req(halt_req),
    .irq_req(irq_req), .irq_ack(irq_ack), .irq_vector(irq_vector), .ime(ime),
    .halted(halted), .halt_bug(halt_bug)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor: compares the response one cycle after each rd_en / irq_ack
  always @(negedge clk) begin
    logic [8:0]  e;
    logic [15:0] v;
    if (rd_armed) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_resp: got hit=%0b data=%02h, required nothing queued", rd_hit, rd_data);
      end else begin
        e = exp_q.pop_front();
        if ({rd_hit, rd_data} !== e) begin
          n_fail++;
          $display("FAIL rd_resp: got hit=%0b data=%02h, required hit=%0b data=%02h",
                   rd_hit, rd_data, e[8], e[7:0]);
        end
      end
    end
    if (ack_armed) begin
      n_tests++;
      if (vec_q.size() == 0) begin
        n_fail++;
        $display("FAIL irq_vector: got %04h, required nothing queued", irq_vector);
      end else begin
        v = vec_q.pop_front();
        if (irq_vector !== v) begin
          n_fail++;
          $display("FAIL irq_vector: got %04h, required %04h", irq_vector, v);
        end
      end
    end
    rd_armed  = rd_en;
    ack_armed = irq_ack;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic hit, input logic [7:0] d);
    addr = a; rd_en = 1'b1;
    exp_q.push_back({hit, d});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_irq(input logic [4:0] p);
    irq_pulse = p;
    tick();
    irq_pulse = '0;
  endtask

  task automatic boundary();
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic ack(input logic [15:0] exp_vec);
    irq_ack = 1'b1;
    vec_q.push_back(exp_vec);
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  initial begin
    // reset state and register reads
    do_reset();
    check("rst_irq_req", 16'(irq_req), 16'h0);
    check("rst_ime", 16'(ime), 16'h0);
    check("rst_halted", 16'(halted), 16'h0);
    check("rst_halt_bug", 16'(halt_bug), 16'h0);
    check("rst_vector", irq_vector, 16'h0000);
    check("rst_rd_hit", 16'(rd_hit), 16'h0);
    bus_read(16'hFF0F, 1'b1, 8'hE0);
    bus_read(16'hFFFF, 1'b1, 8'h00);
    bus_read(16'h1234, 1'b0, 8'h00);
    bus_write(16'hFFFF, 8'hE5);
    bus_read(16'hFFFF, 1'b1, 8'hE5);

    // basic dispatch: IE=05, IF=00101 -> vector 0040, then 0050
    bus_write(16'hFFFF, 8'h05);
    do_reti();
    check("reti_ime", 16'(ime), 16'h1);
    pulse_irq(5'b00101);
    check("req_pending", 16'(irq_req), 16'h1);
    boundary();
    check("req_dispatch", 16'(irq_req), 16'h1);
    ack(16'h0040);
    check("ack_ime", 16'(ime), 16'h0);
    check("ack_req", 16'(irq_req), 16'h0);
    bus_read(16'hFF0F, 1'b1, 8'hE4);
    do_reti();
    boundary();
    ack(16'h0050);
    bus_read(16'hFF0F, 1'b1, 8'hE0);

    // cancelled dispatch: only IF[1], cleared by a bus write before ack
    bus_write(16'hFFFF, 8'h02);
    pulse_irq(5'b00010);
    do_reti();
    boundary();
    bus_write(16'hFF0F, 8'h00);
    check("cancel_req_held", 16'(irq_req), 16'h1);
    ack(16'h0000);
    check("cancel_ime", 16'(ime), 16'h0);
    check("cancel_req", 16'(irq_req), 16'h0);
    // pulse beats a coincident IF write
    bus_write(16'hFF0F, 8'h01);
    irq_pulse = 5'b01000;
    bus_write(16'hFF0F, 8'h00);
    irq_pulse = '0;
    bus_read(16'hFF0F, 1'b1, 8'hE8);

    // di wins over reti
    di = 1'b1; reti = 1'b1;
    tick();
    di = 1'b0; reti = 1'b0;
    check("di_over_reti", 16'(ime), 16'h0);

    // EI delay
    do_reset();
    bus_write(16'hFFFF, 8'h01);
    pulse_irq(5'b00001);
    ei = 1'b1; instr_done = 1'b1;
    tick();
    ei = 1'b0; instr_done = 1'b0;
    check("ei_delay_ime", 16'(ime), 16'h0);
    check("ei_delay_req", 16'(irq_req), 16'h0);
    boundary();
    check("ei_promote_ime", 16'(ime), 16'h1);
    check("ei_promote_req", 16'(irq_req), 16'h1);
    di = 1'b1;
    tick();
    di = 1'b0;
    check("di_req", 16'(irq_req), 16'h0);
    ei = 1'b1; instr_done = 1'b1;
    tick();
    ei = 1'b0;
    di = 1'b1;
    tick();
    di = 1'b0; instr_done = 1'b0;
    check("ei_di_ime", 16'(ime), 16'h0);
    boundary();
    check("ei_di_ime_later", 16'(ime), 16'h0);
    check("ei_di_req_later", 16'(irq_req), 16'h0);

    // HALT with ime=0, wake on IF[2]
    do_reset();
    bus_write(16'hFFFF, 8'h04);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_enter", 16'(halted), 16'h1);
    check("halt_no_bug", 16'(halt_bug), 16'h0);
    tick();
    check("halt_stay", 16'(halted), 16'h1);
    pulse_irq(5'b00100);
    check("halt_wake_edge", 16'(halted), 16'h1);
    tick();
    check("halt_exit", 16'(halted), 16'h0);
    check("halt_exit_req", 16'(irq_req), 16'h0);
    bus_read(16'hFF0F, 1'b1, 8'hE4);

    // HALT with ime=1: request present once RUN is back
    bus_write(16'hFF0F, 8'h00);
    do_reti();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt2_enter", 16'(halted), 16'h1);
    pulse_irq(5'b00100);
    tick();
    check("halt2_exit", 16'(halted), 16'h0);
    check("halt2_req", 16'(irq_req), 16'h1);

    // HALT bug
    do_reset();
    bus_write(16'hFFFF, 8'h01);
    pulse_irq(5'b00001);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("bug_halted", 16'(halted), 16'h0);
    check("bug_pulse", 16'(halt_bug), 16'h1);
    tick();
    check("bug_pulse_end", 16'(halt_bug), 16'h0);
    check("bug_halted_after", 16'(halted), 16'h0);

    // drain scoreboard, bounded
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && vec_q.size() == 0 && !rd_armed && !ack_armed) break;
      tick();
    end
    n_tests++;
    if (exp_q.size() != 0 || vec_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d rd / %0d vec left, required 0", exp_q.size(), vec_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
SM83-style interrupt controller sitting beside the sequencer/decoder. It owns the IE/IF registers, IME and its one-instruction EI delay, and the HALT state. It raises a dispatch request to the sequencer at instruction boundaries and supplies the RST vector during dispatch. Peripherals feed it one-cycle request pulses; the CPU accesses IE (0xFFFF) and IF (0xFF0F) over the memory bus.

Parameters:
NUM_IRQ, 5, number of interrupt sources; bit 0 is highest priority.
VEC_BASE, 8'h40, vector of source 0.
VEC_STRIDE, 8, vector spacing in bytes.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
irq_pulse  in  NUM_IRQ  one-cycle source requests; each sets its IF bit
addr  in  16  CPU bus address
wr_en  in  1  CPU bus write strobe
wr_data  in  8  CPU bus write data
rd_en  in  1  CPU bus read strobe
rd_data  out  8  registered read data
rd_hit  out  1  registered; addr matched IE/IF on the previous rd_en
instr_done  in  1  decoder `done`: instruction boundary this cycle
ei  in  1  EI completing (qualified by instr_done)
di  in  1  DI executing
reti  in  1  RETI executing
halt_req  in  1  HALT executing
irq_req  out  1  dispatch requested to sequencer
irq_ack  in  1  one-cycle pulse from sequencer at the vector-select step of dispatch
irq_vector  out  16  registered dispatch target
ime  out  1  master enable
halted  out  1  CPU stalled in HALT
halt_bug  out  1  one-cycle pulse: HALT skipped with IME=0 and pending non-zero

Behaviour:
- Reset: IE=0, IF=0, ime=0, ime_pend=0, state=RUN, irq_req=0, irq_vector=0, halted=0, halt_bug=0, rd_data=0, rd_hit=0. Reset asserted mid-dispatch or mid-HALT returns to this state immediately.
- pending = IE[NUM_IRQ-1:0] & IF.
- IF update per cycle, priority low to high: bus write (IF <= wr_data[4:0]), then ack clear of the selected bit, then OR with irq_pulse. A set from irq_pulse always wins.
- IE write stores all 8 bits.
- Reads are registered, valid the cycle after rd_en. IF reads {3'b111, IF}. IE reads its stored value. Any other addr gives rd_hit=0 and rd_data=0.
- EI: ei&instr_done sets ime_pend. At the next instr_done with ime_pend=1 (i.e. after the following instruction), ime<=1 and ime_pend<=0.
- di clears ime and ime_pend the same edge; di wins over ei, reti and ime_pend promotion.
- reti sets ime immediately, with no delay.
- States: RUN, HALT, DISPATCH.
- RUN:
  - irq_req = ime & |pending (combinational from registers).
  - instr_done with irq_req=1 goes to DISPATCH.
  - halt_req: if pending!=0 and ime=0, stay in RUN and pulse halt_bug for 1 cycle; otherwise go to HALT, halted=1 from the next cycle.
- HALT:
  - halted=1. Leave for RUN when |pending, regardless of ime; halted drops the next cycle.
  - If ime=1, irq_req rises together with the exit.
- DISPATCH:
  - irq_req held at 1 until irq_ack.
  - On irq_ack: n = lowest set bit of pending at that cycle. irq_vector <= VEC_BASE + n*VEC_STRIDE, IF[n] cleared, ime <= 0, return to RUN.
  - If pending==0 at ack (cancelled by an IF/IE write during dispatch push), irq_vector <= 16'h0000 and IF is unchanged.
- irq_vector holds until the next ack.
- irq_ack outside DISPATCH is ignored.

Decomposition:
- Shared package:
  - irq_t enum: IRQ_VBLANK, IRQ_STAT, IRQ_TIMER, IRQ_SERIAL, IRQ_JOYPAD.
  - int_state_t enum: RUN, HALT, DISPATCH.
  - ADDR_IE=16'hFFFF, ADDR_IF=16'hFF0F.
- Sub-module irq_prio_enc: combinational pending -> {valid, index[2:0]}, lowest index wins.

Test Plan:
- Reset, then read 0xFF0F and 0xFFFF -> rd_data=8'hE0 then 8'h00, rd_hit=1 each cycle after rd_en.
- IE=0x05, ime=1, irq_pulse=5'b00101, instr_done -> irq_req=1. On irq_ack: irq_vector=16'h0040, IF=5'b00100, ime=0.
- EI at instr_done with IF=1, IE=1 -> irq_req stays 0 through the next instruction. It asserts only after the second instr_done; ei followed by di on the next boundary keeps ime=0.
- ime=0, IE=0x04, halt_req -> halted=1. irq_pulse[2] -> halted=0 next cycle, irq_req=0, IF[2] still 1.
- ime=0, IE=IF=0x01, halt_req -> halted stays 0, halt_bug pulses exactly 1 cycle.
- DISPATCH with only IF[1] pending; CPU writes IF=0 before irq_ack -> irq_vector=16'h0000, ime=0. irq_pulse[3] coincident with an IF write of 0 -> IF[3]=1.
